// File: rtl/board_switch_event_ctrl.sv
// board_switch_event_ctrl: synchronizes and debounces board switches, queues each committed change as an event
module board_switch_event_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int SWITCH_WIDTH    = 10,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] ext_board_switch,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH-1:0]   event_data,
  output logic [SWITCH_WIDTH-1:0] event_changed,
  output logic                    event_valid,
  input  logic                    event_ready,
  input  logic                    irq_enable,
  output logic                    irq,
  output logic                    overflow,
  input  logic                    overflow_clear
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;
  state_t state, state_n;
  logic [SWITCH_WIDTH-1:0] sync1, sync_q, stable, cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SWITCH_WIDTH-1:0] mem_d [DEPTH];
  logic [SWITCH_WIDTH-1:0] mem_c [DEPTH];
  logic [SWITCH_WIDTH-1:0] last_d, last_c;
  logic [FIFO_DEPTH_BITS:0] wptr, rptr;
  logic [FIFO_DEPTH_BITS-1:0] widx, ridx;
  logic empty, full, pop, push, wr;
  assign widx = wptr[FIFO_DEPTH_BITS-1:0];
  assign ridx = rptr[FIFO_DEPTH_BITS-1:0];
  assign empty = wptr == rptr;
  assign full = (wptr ^ rptr) == (FIFO_DEPTH_BITS+1)'(DEPTH);
  assign pop = !empty && event_ready;
  assign push = state == COMMIT;
  assign wr = push && (!full || pop);
  assign data = DATA_WIDTH'(stable);
  assign event_valid = !empty;
  assign event_data = DATA_WIDTH'(empty ? last_d : mem_d[ridx]);
  assign event_changed = empty ? last_c : mem_c[ridx];
  // debounce FSM: restart on any new candidate, fall back to IDLE on bounce to the stable value
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    case (state)
      IDLE:
        if (sync_q != stable) begin
          cand_n = sync_q;
          cnt_n = '0;
          state_n = COUNT;
        end
      COUNT:
        if (sync_q != cand) begin
          if (sync_q == stable) state_n = IDLE;
          else begin
            cand_n = sync_q;
            cnt_n = '0;
          end
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) state_n = COMMIT;
        else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // synchronizer, FSM state and stable-state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync_q <= '0;
      stable <= '0;
      cand <= '0;
      cnt <= '0;
      state <= IDLE;
    end else begin
      sync1 <= ext_board_switch;
      sync_q <= sync1;
      state <= state_n;
      cand <= cand_n;
      cnt <= cnt_n;
      if (push) stable <= cand;
    end
  end
  // event storage; contents need no reset because empty pointers hide them
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_d[widx] <= cand;
      mem_c[widx] <= cand ^ stable;
    end
  end
  // FIFO pointers, held head copy, registered irq and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      last_d <= '0;
      last_c <= '0;
      irq <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        last_d <= mem_d[ridx];
        last_c <= mem_c[ridx];
      end
      irq <= !empty && irq_enable;
      overflow <= (push && full && !pop) || (overflow && !overflow_clear);
    end
  end
endmodule

// File: tb/tb_board_switch_event_ctrl.sv
// tb_board_switch_event_ctrl: directed and random stimulus checked against a run-length/queue model
module tb_board_switch_event_ctrl;
  localparam int DW = 16, SW = 10, D = 4, FB = 2, DEPTH = 4;
  logic clk = 0, reset = 0, ready = 0, irq_en = 0, ov_clr = 0;
  logic [SW-1:0] ext = '0;
  logic [DW-1:0] data, event_data;
  logic [SW-1:0] event_changed;
  logic event_valid, irq, overflow;
  int tests = 0, fails = 0;
  typedef struct packed {logic [SW-1:0] c; logic [SW-1:0] d;} ev_t;
  ev_t q[$];
  ev_t m_last;
  logic [SW-1:0] m_p1, m_sq, m_stable, m_runval;
  int m_runlen;
  bit m_commit, m_irq, m_ov;

  board_switch_event_ctrl #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH_BITS(FB)) dut (
    .clk(clk), .reset(reset), .ext_board_switch(ext), .data(data), .event_data(event_data),
    .event_changed(event_changed), .event_valid(event_valid), .event_ready(ready),
    .irq_enable(irq_en), .irq(irq), .overflow(overflow), .overflow_clear(ov_clr));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // a value commits once it has been seen on D+1 consecutive synchronized samples while not committing
  task automatic model_edge();
    bit full, pop, set;
    ev_t e;
    if (!reset) begin
      q.delete();
      m_last = '0; m_p1 = '0; m_sq = '0; m_stable = '0; m_runval = '0;
      m_runlen = 0; m_commit = 0; m_irq = 0; m_ov = 0;
      return;
    end
    full = q.size() == DEPTH;
    pop = q.size() > 0 && ready;
    m_irq = q.size() > 0 && irq_en;
    set = 0;
    if (pop) m_last = q.pop_front();
    if (m_commit) begin
      e.d = m_runval;
      e.c = m_runval ^ m_stable;
      if (!full || pop) q.push_back(e);
      else set = 1;
    end
    m_ov = set ? 1'b1 : ov_clr ? 1'b0 : m_ov;
    if (m_commit) begin
      m_stable = m_runval;
      m_commit = 0;
      m_runlen = 0;
    end else if (m_sq == m_stable) m_runlen = 0;
    else begin
      if (m_runlen > 0 && m_sq == m_runval) m_runlen++;
      else begin
        m_runval = m_sq;
        m_runlen = 1;
      end
      if (m_runlen == D + 1) m_commit = 1;
    end
    m_sq = m_p1;
    m_p1 = ext;
  endtask

  task automatic check_all();
    ev_t h;
    h = q.size() > 0 ? q[0] : m_last;
    chk("data", 32'(data), 32'(m_stable));
    chk("event_valid", 32'(event_valid), 32'(q.size() > 0));
    chk("event_data", 32'(event_data), 32'(h.d));
    chk("event_changed", 32'(event_changed), 32'(h.c));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic wait_commit(input string tag);
    int k;
    k = 0;
    while (!m_commit && k < 50) begin
      step();
      k++;
    end
    if (!m_commit) chk({tag, "_timeout"}, 32'(k), 32'(0));
  endtask

  initial begin
    ext = 10'h3FF;
    hold(3);
    chk("s1_rst_data", 32'(data), 32'(0));
    chk("s1_rst_valid", 32'(event_valid), 32'(0));
    reset = 1;
    hold(8);
    chk("s1_data", 32'(data), 32'h3FF);
    chk("s1_changed", 32'(event_changed), 32'h3FF);
    chk("s1_valid", 32'(event_valid), 32'(1));
    ready = 1;
    ext = '0;
    hold(12);
    ready = 0;
    ext = 10'h005;
    irq_en = 1;
    hold(8);
    chk("s2_data", 32'(data), 32'h0005);
    chk("s2_evdata", 32'(event_data), 32'h0005);
    chk("s2_changed", 32'(event_changed), 32'h005);
    step();
    chk("s2_irq", 32'(irq), 32'(1));
    ready = 1;
    step();
    ready = 0;
    chk("s2_popped", 32'(event_valid), 32'(0));
    step();
    chk("s2_irq_off", 32'(irq), 32'(0));
    ext = '0;
    ready = 1;
    hold(12);
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      ext = ext ^ 10'h001;
      hold(2);
    end
    ext = '0;
    hold(8);
    chk("s3_data", 32'(data), 32'(0));
    chk("s3_valid", 32'(event_valid), 32'(0));
    for (int i = 1; i <= 5; i++) begin
      ext = SW'(10'h100 + i);
      hold(10);
    end
    chk("s4_overflow", 32'(overflow), 32'(1));
    ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("s4_order", 32'(event_data), 32'(10'h100 + i));
      step();
    end
    ready = 0;
    chk("s4_empty", 32'(event_valid), 32'(0));
    ov_clr = 1;
    step();
    ov_clr = 0;
    chk("s4_clear", 32'(overflow), 32'(0));
    for (int i = 1; i <= 4; i++) begin
      ext = SW'(10'h200 + i);
      hold(10);
    end
    ext = 10'h2AA;
    wait_commit("s5a");
    ready = 1;
    step();
    ready = 0;
    chk("s5_ov_stay", 32'(overflow), 32'(0));
    chk("s5_valid", 32'(event_valid), 32'(1));
    chk("s5_head", 32'(event_data), 32'h202);
    ext = 10'h255;
    wait_commit("s5b");
    ov_clr = 1;
    step();
    ov_clr = 0;
    chk("s5_set_wins", 32'(overflow), 32'(1));
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("s5_drain", 32'(event_data), 32'(i == 3 ? 10'h2AA : 10'h202 + i));
      step();
    end
    ready = 0;
    hold(2);
    ext = 10'h011;
    hold(10);
    ext = 10'h022;
    hold(10);
    ext = 10'h033;
    hold(5);
    reset = 0;
    step();
    reset = 1;
    chk("s6_valid", 32'(event_valid), 32'(0));
    chk("s6_data", 32'(data), 32'(0));
    chk("s6_ov", 32'(overflow), 32'(0));
    hold(7);
    chk("s6_not_yet", 32'(data), 32'(0));
    step();
    chk("s6_recommit", 32'(data), 32'h033);
    for (int i = 0; i < 600; i++) begin
      int n;
      if ($urandom_range(3) == 0) ext = m_stable;
      else if ($urandom_range(1) == 1) ext = ext ^ (SW'(1) << $urandom_range(SW - 1));
      else ext = SW'($urandom);
      n = $urandom_range(1, 10);
      repeat (n) begin
        ready = $urandom_range(2) == 0;
        irq_en = $urandom_range(3) != 0;
        ov_clr = $urandom_range(15) == 0;
        reset = $urandom_range(199) != 0;
        step();
      end
    end
    reset = 1;
    ready = 1;
    hold(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
